// File: rtl/global_sram_banked_if.sv
// Request/response bundle for the banked global SRAM. Channel i occupies bit i
// of the vectors and slice [i*W +: W] of the packed buses.
interface global_sram_banked_if #(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 7,
  parameter int DATA_BIT = 16
);
  logic [NUM_CH-1:0]          ch_req;
  logic [NUM_CH-1:0]          ch_wen;
  logic [NUM_CH*ADDR_W-1:0]   ch_addr;
  logic [NUM_CH*DATA_BIT-1:0] ch_wdata;
  logic [NUM_CH-1:0]          ch_gnt;
  logic [NUM_CH-1:0]          ch_rvalid;
  logic [NUM_CH*DATA_BIT-1:0] ch_rdata;

  modport master (
    output ch_req, ch_wen, ch_addr, ch_wdata,
    input  ch_gnt, ch_rvalid, ch_rdata
  );

  modport slave (
    input  ch_req, ch_wen, ch_addr, ch_wdata,
    output ch_gnt, ch_rvalid, ch_rdata
  );
endinterface

// File: rtl/global_sram_banked.sv
// Multi-channel global SRAM: word-interleaved single-port banks, each with its
// own round-robin arbiter, 1-cycle tagged read return and a saturating stall counter.
module global_sram_banked #(
  parameter int DATA_BIT = 16,
  parameter int DEPTH    = 64,
  parameter int NUM_CH   = 4,
  parameter int NUM_BANK = 4,
  parameter int ADDR_W   = $clog2(DEPTH + 1),
  parameter int CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  global_sram_banked_if.slave  bus,
  output logic [CNT_W-1:0]     stall_cnt
);
  localparam int LOG_BANK = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 0;
  localparam int BANK_W   = (NUM_BANK > 1) ? LOG_BANK : 1;
  localparam int ROWS     = DEPTH / NUM_BANK;
  localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PTR_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int POP_W    = $clog2(NUM_CH + 1);

  // Per-channel address decode
  logic [ADDR_W-1:0]   addr     [NUM_CH];
  logic [DATA_BIT-1:0] wdata    [NUM_CH];
  logic [BANK_W-1:0]   bank_sel [NUM_CH];
  logic [ROW_W-1:0]    row      [NUM_CH];
  logic [NUM_CH-1:0]   in_range;

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      addr[i]     = bus.ch_addr[i*ADDR_W +: ADDR_W];
      wdata[i]    = bus.ch_wdata[i*DATA_BIT +: DATA_BIT];
      row[i]      = addr[i][LOG_BANK +: ROW_W];
      in_range[i] = (addr[i] < ADDR_W'(DEPTH));
      bank_sel[i] = (NUM_BANK > 1) ? addr[i][BANK_W-1:0] : '0;
    end
  end

  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] ptr, input int k);
    return PTR_W'((int'(ptr) + k) % NUM_CH);
  endfunction

  // Per-bank round-robin arbitration
  logic [PTR_W-1:0]  rr_ptr   [NUM_BANK];
  logic [PTR_W-1:0]  bank_win [NUM_BANK];
  logic [NUM_BANK-1:0] bank_gnt;
  logic [NUM_CH-1:0] gnt;

  always_comb begin
    gnt = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      bank_gnt[b] = 1'b0;
      bank_win[b] = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (!bank_gnt[b] && bus.ch_req[rr_idx(rr_ptr[b], k)] &&
            bank_sel[rr_idx(rr_ptr[b], k)] == BANK_W'(b)) begin
          bank_gnt[b]                = 1'b1;
          bank_win[b]                = rr_idx(rr_ptr[b], k);
          gnt[rr_idx(rr_ptr[b], k)]  = 1'b1;
        end
      end
    end
  end

  assign bus.ch_gnt = gnt;

  // Bank drive; out-of-range winners are granted but never touch the array
  logic [NUM_BANK-1:0] bank_wen;
  logic [NUM_BANK-1:0] bank_ren;
  logic [ROW_W-1:0]    bank_row   [NUM_BANK];
  logic [DATA_BIT-1:0] bank_wdata [NUM_BANK];
  logic [DATA_BIT-1:0] bank_rdata [NUM_BANK];

  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      bank_wen[b]   = 1'b0;
      bank_ren[b]   = 1'b0;
      bank_row[b]   = '0;
      bank_wdata[b] = '0;
      if (bank_gnt[b]) begin
        bank_row[b]   = row[bank_win[b]];
        bank_wdata[b] = wdata[bank_win[b]];
        bank_wen[b]   = bus.ch_wen[bank_win[b]] & in_range[bank_win[b]];
        bank_ren[b]   = ~bus.ch_wen[bank_win[b]] & in_range[bank_win[b]];
      end
    end
  end

  logic [DATA_BIT-1:0] mem [NUM_BANK][ROWS];

  // NOTE: the storage array and its read register have no reset; contents survive rstn.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANK; b++) begin
      if (bank_wen[b]) mem[b][bank_row[b]] <= bank_wdata[b];
      if (bank_ren[b]) bank_rdata[b] <= mem[b][bank_row[b]];
    end
  end

  // Read return tagging and stall accounting
  logic [NUM_CH-1:0] rd_acc;
  logic [NUM_CH-1:0] rvalid;
  logic [NUM_CH-1:0] rd_oor;
  logic [BANK_W-1:0] bank_id [NUM_CH];
  logic [POP_W-1:0]  stall_pop;
  logic [CNT_W:0]    stall_sum;

  assign rd_acc = bus.ch_req & gnt & ~bus.ch_wen;

  always_comb begin
    stall_pop = '0;
    for (int i = 0; i < NUM_CH; i++)
      stall_pop = stall_pop + POP_W'(bus.ch_req[i] & ~gnt[i]);
    stall_sum = {1'b0, stall_cnt} + (CNT_W+1)'(stall_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid    <= '0;
      rd_oor    <= '0;
      stall_cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) bank_id[i] <= '0;
      for (int b = 0; b < NUM_BANK; b++) rr_ptr[b] <= '0;
    end else begin
      rvalid    <= rd_acc;
      stall_cnt <= stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_acc[i]) begin
          bank_id[i] <= bank_sel[i];
          rd_oor[i]  <= ~in_range[i];
        end
      end
      for (int b = 0; b < NUM_BANK; b++)
        if (bank_gnt[b]) rr_ptr[b] <= PTR_W'((int'(bank_win[b]) + 1) % NUM_CH);
    end
  end

  assign bus.ch_rvalid = rvalid;

  always_comb begin
    bus.ch_rdata = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (rvalid[i] && !rd_oor[i])
        bus.ch_rdata[i*DATA_BIT +: DATA_BIT] = bank_rdata[bank_id[i]];
  end
endmodule

// File: doc/global_sram_banked.md
Name: global_sram_banked

Overview:
- Multi-channel, multi-bank global SRAM. Replaces the single-port global buffer memory.
- NUM_CH requesters (array/GBUS-side masters) share NUM_BANK single-port `mem_sp` banks through word-interleaved addressing.
- Each bank has its own round-robin arbiter, so requests to different banks are served in parallel.
- Reads return with fixed 1-cycle latency, tagged per channel. A saturating stall counter supports performance debug.

Parameters:
- DATA_BIT, `ARR_GBUS_DATA, word width in bits.
- DEPTH, `GLOBAL_SRAM_DEPTH, total words across all banks. Must be a multiple of NUM_BANK.
- NUM_CH, 4, number of requester channels (>=1).
- NUM_BANK, 4, number of banks (power of 2, >=1).
- ADDR_W, $clog2(DEPTH+1), per-channel word-address width (derived).
- CNT_W, 32, stall-counter width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- ch_req  in  NUM_CH  per-channel request. Held with its command until granted.
- ch_wen  in  NUM_CH  1 = write, 0 = read. Qualified by ch_req.
- ch_addr  in  NUM_CH*ADDR_W  packed word addresses; channel i at [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*DATA_BIT  packed write data.
- ch_gnt  out  NUM_CH  combinational grant; the command is accepted on the clk edge where req&gnt=1.
- ch_rvalid  out  NUM_CH  read data valid, one cycle after an accepted read.
- ch_rdata  out  NUM_CH*DATA_BIT  packed read data; meaningful only while the matching ch_rvalid=1.
- stall_cnt  out  CNT_W  saturating count of channel-cycles with req=1 and gnt=0.

Behaviour:
- Address map:
  - bank = addr[log2(NUM_BANK)-1:0]; row = addr >> log2(NUM_BANK).
  - Each bank is a `mem_sp` of depth DEPTH/NUM_BANK. With NUM_BANK=1 the bank field is empty and row = addr.
- Arbitration (per bank, combinational):
  - Among the channels requesting that bank, grant the first at or after rr_ptr[bank], searching in increasing index with wrap-around.
  - At most one grant per bank per cycle. At most one grant per channel (a channel targets exactly one bank).
  - On a grant, rr_ptr[bank] <= granted_index+1 mod NUM_CH. rr_ptr is unchanged when the bank has no grant.
- Bank drive:
  - Granted write: wen=1, wdata and row from the winner; data is committed at that edge.
  - Granted read: ren=1.
  - No grant: wen=0, ren=0.
- Read return:
  - Read accepted at edge T gives ch_rvalid[i]=1 during cycle T..T+1 (exactly one cycle).
  - ch_rdata[i] is selected from the bank rdata using a per-channel bank-id register captured at T.
  - Back-to-back reads by one channel give consecutive rvalid pulses.
  - ch_rdata is 0 whenever ch_rvalid=0.
- Writes produce no response. A read of an address accepted in the cycle after a write to it returns the new data.
- Out-of-range address (addr >= DEPTH):
  - Still arbitrated and granted, so no deadlock.
  - Write is dropped (bank wen held 0).
  - Read pulses rvalid with rdata=0.
- Stall counter:
  - Each cycle, stall_cnt += popcount(ch_req & ~ch_gnt).
  - Saturates at 2^CNT_W-1; never wraps.
- Reset (rstn=0, asynchronous):
  - Outputs: ch_rvalid=0, stall_cnt=0. ch_gnt is combinational and drops only because ch_req is expected low during reset.
  - Internal state: all rr_ptr=0, bank-id registers=0.
  - SRAM contents are not reset.
  - Reads in flight when reset asserts never produce rvalid.
- No state change while ch_req=0 on every channel, except completion of in-flight rvalid.

Test Plan:
- Single channel, NUM_CH=4/NUM_BANK=4: ch0 writes 0xA5 to addr 6, then reads addr 6 → gnt same cycle each; ch_rvalid[0]=1 exactly one cycle after the read edge with rdata=0xA5; stall_cnt=0.
- Parallel banks: ch0..ch3 read addrs 0,1,2,3 in the same cycle → all four granted; four rvalid the next cycle with the correct words; stall_cnt unchanged.
- Bank conflict, round-robin: ch0..ch3 all hold reads to addr 4 (bank 0) → grants in order ch0,ch1,ch2,ch3 over 4 cycles; stall_cnt = 3+2+1 = 6. Repeating the burst starts from ch0 (pointer wrapped).
- Read-after-write: ch1 writes 0x1234 to addr 9 at edge T; ch2 reads addr 9 at T+1 → ch2 rdata=0x1234 at T+2.
- Out-of-range: read at addr DEPTH → granted, rvalid=1, rdata=0. Write to addr DEPTH → no bank contents change (verify by reading all rows).
- Reset mid-operation: assert rstn=0 asynchronously in the cycle after a read is accepted → rvalid=0 immediately, stall_cnt=0. After release, arbitration restarts at ch0 and earlier-written data is still readable.
